data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Load/store controller between the RISC-V core's memory stage and the 1536×8 byte-wide data RAM. It accepts byte, halfword and word requests over a valid/ready handshake and serialises them into little-endian single-byte RAM accesses. Loads are returned sign- or zero-extended to 32 bits. Misaligned and out-of-range requests are rejected without touching the RAM.

## Interface
Parameters:
- ADDR_W, 11, byte address width; the RAM decodes 1536 bytes (0x000–0x5FF).

Ports:
- clk  in  1  single clock; RAM RCLK and WCLK are driven from the same net.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; the request is accepted on `req_valid && req_ready`.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: request rejected.
- resp_rdata  out  32  load result; 0 for stores and errors.
- ram_re  out  1  to RAM RE.
- ram_raddr  out  ADDR_W  to RAM RADDR.
- ram_rdata  in  8  from RAM RDATA_OUT.
- ram_we  out  1  to RAM WE.
- ram_waddr  out  ADDR_W  to RAM WADDR.
- ram_wdata  out  8  to RAM WDATA.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_CAP, RESP.
- req_ready = (state == IDLE) && !reset.
- On accept, the controller latches we, size, unsigned, addr and wdata.
  - nbytes = 1, 2 or 4 per req_size.
  - cnt = 0.
- Error check at accept. A request is an error if any of the following hold:
  - req_size == 3;
  - req_size == 1 and addr[0] == 1;
  - req_size == 2 and addr[1:0] != 0;
  - addr[10:9] == 2'b11.
- Error path: go to RESP with err = 1 and rdata = 0. No RAM strobe is asserted.
- Store path, state WRITE:
  - ram_we = 1, ram_waddr = addr + cnt, ram_wdata = wdata[8*cnt+7 : 8*cnt].
  - cnt increments each cycle.
  - After byte nbytes-1, go to RESP.
- Load path, two cycles per byte, because the RAM output mux follows the live RADDR bank:
  - RD_ISSUE: ram_re = 1, ram_raddr = addr + cnt.
  - RD_CAP: ram_re = 1, same address held; ram_rdata is stored into byte lane cnt of the assembly register.
  - From RD_CAP, increment cnt and return to RD_ISSUE, or go to RESP after the last byte.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - Load result: byte → bit 7 extended; half → bit 15 extended. Zero-extend when unsigned, sign-extend otherwise. Word is passed unchanged.
- An aligned access never crosses a bank boundary.
- The address adder is ADDR_W bits wide. Wrap-around is unreachable after the range check.
- All RAM-side and response outputs are registered.
- ram_re and ram_we are never asserted in the same cycle.

## Timing
- Accept cycle = cycle 0.
- Store of N bytes: ram_we high in cycles 1..N; resp_valid in cycle N+1.
  - sw = resp at cycle 5.
- Load of N bytes: RAM active in cycles 1..2N; resp_valid in cycle 2N+1.
  - lw = resp at cycle 9.
- Error: resp_valid, resp_err in cycle 1.
- Next accept is possible in the cycle after resp_valid.
- There is no response backpressure. The core must sample resp_valid.
- A req_valid held while busy is ignored. It must stay asserted until req_ready.
- Reset, including mid-operation:
  - Next state is IDLE and in-flight state is discarded: no response, no further RAM strobes.
  - Bytes already written stay written.
  - All outputs are 0 while reset is high.
  - req_ready becomes 1 in the first cycle after reset deasserts.

## Test plan
- sw addr 0x010, wdata 0xDEADBEEF → ram_we at cycles 1–4 with (addr, data) = (0x010,EF), (0x011,BE), (0x012,AD), (0x013,DE); resp_valid at cycle 5, err = 0.
- lw 0x010 after the store above → ram_re in cycles 1–8; resp_rdata = 0xDEADBEEF at cycle 9.
- Byte 0x80 at 0x1FF: lb → 0xFFFFFF80; lbu → 0x00000080.
  - Halfword 0x8001 at 0x200: lh → 0xFFFF8001.
  - This covers the bank0/bank1 edge.
- lh 0x011, sw 0x002, lw 0x600, size = 3 → each gives resp_err = 1 at cycle 1 and zero RAM strobes.
- Assert reset at cycle 2 of an sw to 0x020 → ram_we low from the reset cycle on, no resp_valid, req_ready = 1 after release.
  - A subsequent lw 0x020 reads back only byte 0 changed.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store controller: serialises byte/half/word core requests into
// little-endian single-byte accesses on a 1536x8 synchronous-read data RAM.
module data_mem_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAP,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;

    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] byte_addr;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Misaligned accesses and the unpopulated top quarter of the map are rejected.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = |req_addr[1:0];
            2'd3:    req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr[ADDR_W-1 -: 2] == 2'b11) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        last_d  = last_q;
        if (accept) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            err_d   = req_err;
            case (req_size)
                2'd0:    last_d = 2'd0;
                2'd1:    last_d = 2'd1;
                default: last_d = 2'd3;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_q) begin
                    state_d = RESP;
                end
            end
            RD_ISSUE: state_d = RD_CAP;
            RD_CAP: begin
                if (cnt_q == last_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = RD_ISSUE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM data for the byte issued last cycle is valid during RD_CAP.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d = '0;
        end else if (state_q == RD_CAP) begin
            asm_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
        end
    end

    // Outputs are computed from the next state so they are registered yet align with it.
    always_comb begin
        byte_addr   = addr_d + ADDR_W'(cnt_d);
        ram_we_d    = (state_d == WRITE);
        ram_waddr_d = ram_we_d ? byte_addr : '0;
        ram_wdata_d = ram_we_d ? wdata_d[{cnt_d, 3'b000} +: 8] : 8'h00;
        ram_re_d    = (state_d == RD_ISSUE) || (state_d == RD_CAP);
        ram_raddr_d = ram_re_d ? byte_addr : '0;
        resp_valid_d = (state_d == RESP);
        resp_err_d   = resp_valid_d && err_d;
        resp_rdata_d = '0;
        if (resp_valid_d && !err_d && !we_d) begin
            case (size_d)
                2'd0:    resp_rdata_d = {{24{asm_d[7]  && !uns_d}}, asm_d[7:0]};
                2'd1:    resp_rdata_d = {{16{asm_d[15] && !uns_d}}, asm_d[15:0]};
                default: resp_rdata_d = asm_d;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            ram_re_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_raddr_q  <= '0;
            ram_waddr_q  <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            ram_re_q     <= ram_re_d;
            ram_we_q     <= ram_we_d;
            ram_raddr_q  <= ram_raddr_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Gating by reset stops an in-flight strobe in the very cycle reset rises.
    assign ram_re     = ram_re_q && !reset;
    assign ram_we     = ram_we_q && !reset;
    assign ram_raddr  = reset ? '0 : ram_raddr_q;
    assign ram_waddr  = reset ? '0 : ram_waddr_q;
    assign ram_wdata  = reset ? '0 : ram_wdata_q;
    assign resp_valid = resp_valid_q && !reset;
    assign resp_err   = resp_err_q && !reset;
    assign resp_rdata = reset ? '0 : resp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a synchronous-read byte RAM model plus a
// reference byte array updated by load/store semantics.
module tb_data_mem_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [7:0]    ramRdata = 8'h00;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;

    logic          fillRam;
    logic [7:0]    seedBase;
    logic [7:0]    ramMem [0:1535];
    logic [7:0]    refMem [0:1535];

    int vectors = 0;
    int miscompares = 0;

    logic          trWe    [1:11];
    logic [AW-1:0] trWaddr [1:11];
    logic [7:0]    trWdata [1:11];
    logic          trRe    [1:11];
    logic [AW-1:0] trRaddr [1:11];
    logic          trRv    [1:11];
    logic          trErr   [1:11];
    logic [31:0]   trRdata [1:11];
    logic          trReady [1:11];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .ram_re       (ram_re),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ramRdata),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata)
    );

    // Synchronous-read RAM: data for an address presented this cycle appears next cycle.
    always @(posedge clk) begin
        if (fillRam) begin
            for (int i = 0; i < 1536; i++) ramMem[i] <= 8'(i * 7) ^ seedBase;
        end else begin
            if (ram_we && int'(ram_waddr) < 1536) ramMem[int'(ram_waddr)] <= ram_wdata;
            if (ram_re) ramRdata <= (int'(ram_raddr) < 1536) ? ramMem[int'(ram_raddr)] : 8'h00;
        end
    end

    function automatic int nBytes(input logic [1:0] size);
        return (size == 2'd3) ? 1 : (1 << size);
    endfunction

    function automatic bit isErr(input logic [1:0] size, input logic [AW-1:0] addr);
        int a = int'(addr);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
               (size == 2'd2 && a % 4 != 0) || (a >= 1536);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                              input logic [AW-1:0] addr);
        int n = nBytes(size);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(refMem[int'(addr) + i]) << (8 * i);
        if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [AW-1:0] addr,
                              input logic [31:0] wd);
        for (int i = 0; i < nBytes(size); i++) refMem[int'(addr) + i] = wd[8 * i +: 8];
    endtask

    task automatic runReq(input logic we, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [31:0] wd, input int ncyc);
        int waitCnt = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        while (!req_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        vectors++;
        if (!req_ready) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout: req_ready %b, required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            trWe[c]    = ram_we;
            trWaddr[c] = ram_waddr;
            trWdata[c] = ram_wdata;
            trRe[c]    = ram_re;
            trRaddr[c] = ram_raddr;
            trRv[c]    = resp_valid;
            trErr[c]   = resp_err;
            trRdata[c] = resp_rdata;
            trReady[c] = req_ready;
        end
    endtask

    task automatic test_reset();
        seedBase     = 8'($urandom);
        for (int i = 0; i < 1536; i++) refMem[i] = 8'(i * 7) ^ seedBase;
        reset        = 1'b1;
        fillRam      = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 4;
        if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", req_ready); end
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rv: got %b want 0", resp_valid); end
        if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b want 0", ram_we); end
        if (ram_re !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_re: got %b want 0", ram_re); end
        @(posedge clk);
        #1;
        fillRam = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_store_word();
        logic [31:0] wd = 32'hDEADBEEF;
        runReq(1'b1, 2'd2, 1'b0, 11'h010, wd, 6);
        modelStore(2'd2, 11'h010, wd);
        for (int c = 1; c <= 6; c++) begin
            vectors += 3;
            if (trWe[c] !== (c <= 4)) begin miscompares++; $display("[TB] FAIL sw_we c%0d: got %b want %b", c, trWe[c], c <= 4); end
            if (trRe[c] !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_re c%0d: got %b want 0", c, trRe[c]); end
            if (trRv[c] !== (c == 5)) begin miscompares++; $display("[TB] FAIL sw_rv c%0d: got %b want %b", c, trRv[c], c == 5); end
            if (c <= 4) begin
                vectors += 2;
                if (trWaddr[c] !== 11'(16 + c - 1)) begin miscompares++; $display("[TB] FAIL sw_waddr c%0d: got %h want %h", c, trWaddr[c], 11'(16 + c - 1)); end
                if (trWdata[c] !== wd[8 * (c - 1) +: 8]) begin miscompares++; $display("[TB] FAIL sw_wdata c%0d: got %h want %h", c, trWdata[c], wd[8 * (c - 1) +: 8]); end
            end
        end
        vectors++;
        if (trErr[5] !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_err: got %b want 0", trErr[5]); end
    endtask

    task automatic test_load_word();
        runReq(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 10);
        for (int c = 1; c <= 10; c++) begin
            vectors += 3;
            if (trRe[c] !== (c <= 8)) begin miscompares++; $display("[TB] FAIL lw_re c%0d: got %b want %b", c, trRe[c], c <= 8); end
            if (trWe[c] !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_we c%0d: got %b want 0", c, trWe[c]); end
            if (trRv[c] !== (c == 9)) begin miscompares++; $display("[TB] FAIL lw_rv c%0d: got %b want %b", c, trRv[c], c == 9); end
            if (c <= 8) begin
                vectors++;
                if (trRaddr[c] !== 11'(16 + (c - 1) / 2)) begin miscompares++; $display("[TB] FAIL lw_raddr c%0d: got %h want %h", c, trRaddr[c], 11'(16 + (c - 1) / 2)); end
            end
        end
        vectors++;
        if (trRdata[9] !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL lw_rdata: got %h want deadbeef", trRdata[9]); end
    endtask

    task automatic test_sign_extend();
        logic        tWe   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  tSize [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        logic        tUns  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [10:0] tAddr [6] = '{11'h1FF, 11'h200, 11'h1FF, 11'h1FF, 11'h200, 11'h200};
        logic [31:0] tWd   [6] = '{32'h80, 32'h8001, 0, 0, 0, 0};
        logic [31:0] tExp  [6] = '{0, 0, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        for (int k = 0; k < 6; k++) begin
            int n = nBytes(tSize[k]);
            int rc = tWe[k] ? n + 1 : 2 * n + 1;
            runReq(tWe[k], tSize[k], tUns[k], tAddr[k], tWd[k], rc);
            if (tWe[k]) modelStore(tSize[k], tAddr[k], tWd[k]);
            vectors += 3;
            if (trRv[rc] !== 1'b1) begin miscompares++; $display("[TB] FAIL ext_rv #%0d: got %b want 1", k, trRv[rc]); end
            if (trErr[rc] !== 1'b0) begin miscompares++; $display("[TB] FAIL ext_err #%0d: got %b want 0", k, trErr[rc]); end
            if (trRdata[rc] !== tExp[k]) begin miscompares++; $display("[TB] FAIL ext_rdata #%0d: got %h want %h", k, trRdata[rc], tExp[k]); end
        end
    endtask

    task automatic test_errors();
        logic        tWe   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  tSize [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
        logic [10:0] tAddr [4] = '{11'h011, 11'h002, 11'h600, 11'h040};
        for (int k = 0; k < 4; k++) begin
            int strobes = 0;
            runReq(tWe[k], tSize[k], 1'b0, tAddr[k], 32'hA5A5A5A5, 3);
            for (int c = 1; c <= 3; c++) strobes += int'(trWe[c]) + int'(trRe[c]);
            vectors += 5;
            if (trRv[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL err_rv #%0d: got %b want 1", k, trRv[1]); end
            if (trErr[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL err_flag #%0d: got %b want 1", k, trErr[1]); end
            if (trRdata[1] !== 32'h0) begin miscompares++; $display("[TB] FAIL err_rdata #%0d: got %h want 0", k, trRdata[1]); end
            if (strobes !== 0) begin miscompares++; $display("[TB] FAIL err_strobes #%0d: got %0d want 0", k, strobes); end
            if (trReady[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL err_ready #%0d: got %b want 1", k, trReady[2]); end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] wd = $urandom;
        logic [31:0] expRd;
        int bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 11'h020; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_c1_we: got %b want 1", ram_we); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we: got %b want 0", ram_we); end
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rv: got %b want 0", resp_valid); end
        if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready: got %b want 0", req_ready); end
        if (resp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_rdata: got %h want 0", resp_rdata); end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bad += int'(ram_we) + int'(resp_valid) + int'(ram_re);
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("[TB] FAIL rst_quiet: got %0d strobes want 0", bad); end
        refMem[32] = wd[7:0];
        expRd = modelLoad(2'd2, 1'b0, 11'h020);
        runReq(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 10);
        vectors++;
        if (trRdata[9] !== expRd) begin miscompares++; $display("[TB] FAIL rst_readback: got %h want %h", trRdata[9], expRd); end
    endtask

    task automatic test_back_to_back_random();
        for (int it = 0; it < 80; it++) begin
            logic        we   = 1'($urandom);
            logic        uns  = 1'($urandom);
            logic [1:0]  size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            logic [31:0] wd   = $urandom;
            logic [10:0] addr;
            int n = nBytes(size);
            bit err;
            int rc;
            logic [31:0] expRd;
            if ($urandom_range(0, 9) < 2) addr = 11'($urandom_range(0, 2047));
            else addr = 11'($urandom_range(32'h1F0, 32'h20F) & ~(n - 1));
            err   = isErr(size, addr);
            rc    = err ? 1 : (we ? n + 1 : 2 * n + 1);
            expRd = (err || we) ? 32'h0 : modelLoad(size, uns, addr);
            runReq(we, size, uns, addr, wd, rc + 1);
            if (!err && we) modelStore(size, addr, wd);
            for (int c = 1; c <= rc + 1; c++) begin
                logic eWe = !err && we && c <= n;
                logic eRe = !err && !we && c <= 2 * n;
                vectors += 4;
                if (trWe[c] !== eWe) begin miscompares++; $display("[TB] FAIL rnd_we #%0d c%0d: got %b want %b", it, c, trWe[c], eWe); end
                if (trRe[c] !== eRe) begin miscompares++; $display("[TB] FAIL rnd_re #%0d c%0d: got %b want %b", it, c, trRe[c], eRe); end
                if (trRv[c] !== (c == rc)) begin miscompares++; $display("[TB] FAIL rnd_rv #%0d c%0d: got %b want %b", it, c, trRv[c], c == rc); end
                if (trReady[c] !== (c > rc)) begin miscompares++; $display("[TB] FAIL rnd_ready #%0d c%0d: got %b want %b", it, c, trReady[c], c > rc); end
                if (eWe) begin
                    vectors += 2;
                    if (trWaddr[c] !== 11'(addr + c - 1)) begin miscompares++; $display("[TB] FAIL rnd_waddr #%0d c%0d: got %h want %h", it, c, trWaddr[c], 11'(addr + c - 1)); end
                    if (trWdata[c] !== wd[8 * (c - 1) +: 8]) begin miscompares++; $display("[TB] FAIL rnd_wdata #%0d c%0d: got %h want %h", it, c, trWdata[c], wd[8 * (c - 1) +: 8]); end
                end
                if (eRe) begin
                    vectors++;
                    if (trRaddr[c] !== 11'(addr + (c - 1) / 2)) begin miscompares++; $display("[TB] FAIL rnd_raddr #%0d c%0d: got %h want %h", it, c, trRaddr[c], 11'(addr + (c - 1) / 2)); end
                end
                if (c == rc) begin
                    vectors += 2;
                    if (trErr[c] !== err) begin miscompares++; $display("[TB] FAIL rnd_err #%0d: got %b want %b", it, trErr[c], err); end
                    if (trRdata[c] !== expRd) begin miscompares++; $display("[TB] FAIL rnd_rdata #%0d: got %h want %h", it, trRdata[c], expRd); end
                end
            end
        end
    endtask

    initial begin
        $display("[TB] starting data_mem_ctrl bench");
        test_reset();
        test_store_word();
        test_load_word();
        test_sign_extend();
        test_errors();
        test_reset_mid_store();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
